// File: rtl/common_pkg.sv
// Shared types for the can_clic interrupt arbiter and its sequencer.
//   IRQ_COUNT : number of interrupt sources
//   PRIO_W    : priority / threshold width
//   Prio      : one priority value
//   Entries   : arbiter input vector, [IRQ_COUNT] is the threshold, [i] is source i
//   Index     : source index, IRQ_COUNT means "no source"
package common_pkg;
  localparam int unsigned IRQ_COUNT = 3;
  localparam int unsigned PRIO_W    = 3;
  localparam int unsigned IDX_W     = $clog2(IRQ_COUNT + 1);

  typedef logic [PRIO_W-1:0] Prio;
  typedef Prio [IRQ_COUNT:0] Entries;
  typedef logic [IDX_W-1:0]  Index;
endpackage

// File: rtl/can_clic.sv
// Combinational interrupt arbiter.
//   entries_i      : [IRQ_COUNT] = threshold, [i] = effective priority of source i
//   is_interrupt_o : some source is strictly above the threshold
//   index_o        : winning source, IRQ_COUNT when none
// Ties between sources go to the lowest index; a tie with the threshold never wins.
module can_clic
  import common_pkg::*;
(
  input  Entries entries_i,
  output logic   is_interrupt_o,
  output Index   index_o
);

  Prio best;

  always_comb begin
    best           = entries_i[IRQ_COUNT];
    index_o        = Index'(IRQ_COUNT);
    is_interrupt_o = 1'b0;
    for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
      if (entries_i[i] > best) begin
        best           = entries_i[i];
        index_o        = Index'(i);
        is_interrupt_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_clic_ctrl.sv
// Sequencer around can_clic: edge-latched pending bits, per-source priority/enable,
// a base threshold plus a nesting stack of preemption thresholds, and a registered
// req/ack offer to the core.
//   clk, rst_n   : clock, asynchronous active-low reset
//   irq_i        : raw interrupt lines (rising-edge sensitive)
//   cfg_*        : config write (sel < IRQ_COUNT -> source, sel == IRQ_COUNT -> base threshold)
//   irq_req_o    : interrupt offered; irq_id_o / irq_prio_o describe it
//   irq_ack_i    : core takes the offer; irq_done_i : core leaves current level
//   level_o      : nesting depth; err_o : one-cycle protocol error pulse
module can_clic_ctrl
  import common_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IRQ_COUNT-1:0]         irq_i,
  input  logic                         cfg_we_i,
  input  logic [IDX_W-1:0]             cfg_sel_i,
  input  logic [PRIO_W-1:0]            cfg_prio_i,
  input  logic                         cfg_en_i,
  output logic                         irq_req_o,
  output logic [IDX_W-1:0]             irq_id_o,
  output logic [PRIO_W-1:0]            irq_prio_o,
  input  logic                         irq_ack_i,
  input  logic                         irq_done_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         err_o
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [IRQ_COUNT-1:0] irq_q;
  logic [IRQ_COUNT-1:0] pending;
  logic [IRQ_COUNT-1:0] en;
  Prio                  prio [IRQ_COUNT];
  Prio                  base_thr;
  Prio                  stack [DEPTH];
  logic [LVL_W-1:0]     depth;

  logic [IRQ_COUNT-1:0] set_mask;
  logic [IRQ_COUNT-1:0] clr_mask;
  logic                 take;
  logic                 done_ok;
  logic                 proto_err;
  logic                 stack_full;
  Prio                  cur_thr;
  Prio                  win_prio;
  Entries               entries;
  logic                 is_int;
  Index                 win_idx;

  always_comb begin
    set_mask = irq_i & ~irq_q;
    take     = irq_ack_i & irq_req_o;

    clr_mask = '0;
    for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
      if (take && (irq_id_o == Index'(i))) clr_mask[i] = 1'b1;
    end

    // Top of stack selected by compare instead of depth-1 indexing, so DEPTH=1 works.
    cur_thr = base_thr;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (depth == LVL_W'(i + 1)) cur_thr = stack[i];
    end

    entries[IRQ_COUNT] = cur_thr;
    for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
      entries[i] = (pending[i] && en[i]) ? prio[i] : '0;
    end

    stack_full = (depth == LVL_W'(DEPTH));
    // A done arriving with an ack is dropped; the ack wins.
    done_ok    = irq_done_i && !irq_ack_i && (depth != '0);
    proto_err  = (irq_ack_i && !irq_req_o) ||
                 (irq_ack_i && irq_done_i) ||
                 (irq_done_i && (depth == '0));
  end

  can_clic u_clic (
    .entries_i      (entries),
    .is_interrupt_o (is_int),
    .index_o        (win_idx)
  );

  always_comb begin
    win_prio = '0;
    for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
      if (win_idx == Index'(i)) win_prio = prio[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q      <= '0;
      pending    <= '0;
      en         <= '0;
      base_thr   <= '0;
      depth      <= '0;
      irq_req_o  <= 1'b0;
      irq_id_o   <= Index'(IRQ_COUNT);
      irq_prio_o <= '0;
      err_o      <= 1'b0;
      for (int unsigned i = 0; i < IRQ_COUNT; i++) prio[i]  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)     stack[i] <= '0;
    end else begin
      irq_q   <= irq_i;
      // Set after clear: a new edge on the source being acked stays pending.
      pending <= (pending & ~clr_mask) | set_mask;

      if (cfg_we_i) begin
        if (cfg_sel_i == Index'(IRQ_COUNT)) begin
          base_thr <= cfg_prio_i;
        end else begin
          for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
            if (cfg_sel_i == Index'(i)) begin
              prio[i] <= cfg_prio_i;
              en[i]   <= cfg_en_i;
            end
          end
        end
      end

      if (take) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (depth == LVL_W'(i)) stack[i] <= irq_prio_o;
        end
        depth <= depth + LVL_W'(1);
      end else if (done_ok) begin
        depth <= depth - LVL_W'(1);
      end

      irq_req_o  <= is_int && !stack_full && !take;
      irq_id_o   <= win_idx;
      irq_prio_o <= win_prio;
      err_o      <= proto_err;
    end
  end

  assign level_o = depth;

endmodule

// File: tb/tb_can_clic_ctrl.sv
module tb_can_clic_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] irq_i;
  logic       cfg_we_i;
  logic [1:0] cfg_sel_i;
  logic [2:0] cfg_prio_i;
  logic       cfg_en_i;
  logic       irq_req_o;
  logic [1:0] irq_id_o;
  logic [2:0] irq_prio_o;
  logic       irq_ack_i;
  logic       irq_done_i;
  logic [2:0] level_o;
  logic       err_o;

  can_clic_ctrl #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_i      (irq_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_sel_i  (cfg_sel_i),
    .cfg_prio_i (cfg_prio_i),
    .cfg_en_i   (cfg_en_i),
    .irq_req_o  (irq_req_o),
    .irq_id_o   (irq_id_o),
    .irq_prio_o (irq_prio_o),
    .irq_ack_i  (irq_ack_i),
    .irq_done_i (irq_done_i),
    .level_o    (level_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] irq;
    logic       we;
    logic [1:0] sel;
    logic [2:0] p;
    logic       en;
    logic       ack;
    logic       done;
    logic       req;
    logic [1:0] id;
    logic [2:0] prio;
    logic [2:0] lvl;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void v(input logic [2:0] irq, input logic we, input logic [1:0] sel,
                            input logic [2:0] p, input logic en, input logic ack,
                            input logic done, input logic req, input logic [1:0] id,
                            input logic [2:0] prio, input logic [2:0] lvl, input logic err);
    vec_t r;
    r.irq = irq; r.we = we; r.sel = sel; r.p = p; r.en = en; r.ack = ack; r.done = done;
    r.req = req; r.id = id; r.prio = prio; r.lvl = lvl; r.err = err;
    vecs.push_back(r);
  endfunction

  // Shorthands: idle, ack, done, config write, irq pulse
  function automatic void vi(input logic req, input logic [1:0] id, input logic [2:0] prio,
                             input logic [2:0] lvl, input logic err);
    v(3'b000, 0, 0, 0, 0, 0, 0, req, id, prio, lvl, err);
  endfunction
  function automatic void va(input logic req, input logic [1:0] id, input logic [2:0] prio,
                             input logic [2:0] lvl, input logic err);
    v(3'b000, 0, 0, 0, 0, 1, 0, req, id, prio, lvl, err);
  endfunction
  function automatic void vd(input logic req, input logic [1:0] id, input logic [2:0] prio,
                             input logic [2:0] lvl, input logic err);
    v(3'b000, 0, 0, 0, 0, 0, 1, req, id, prio, lvl, err);
  endfunction
  function automatic void vc(input logic [1:0] sel, input logic [2:0] p, input logic en,
                             input logic [2:0] lvl);
    v(3'b000, 1, sel, p, en, 0, 0, 0, 2'd3, 3'd0, lvl, 0);
  endfunction
  function automatic void vp(input logic [2:0] irq, input logic [2:0] lvl);
    v(irq, 0, 0, 0, 0, 0, 0, 0, 2'd3, 3'd0, lvl, 0);
  endfunction

  task automatic chk(input string name, input logic req, input logic [1:0] id,
                     input logic [2:0] prio, input logic [2:0] lvl, input logic err);
    logic [9:0] got, exp;
    got = {irq_req_o, irq_id_o, irq_prio_o, level_o, err_o};
    exp = {req, id, prio, lvl, err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got req=%b id=%0d prio=%0d lvl=%0d err=%b, expected req=%b id=%0d prio=%0d lvl=%0d err=%b",
               name, irq_req_o, irq_id_o, irq_prio_o, level_o, err_o, req, id, prio, lvl, err);
    end
  endtask

  task automatic drive(input logic [2:0] irq, input logic we, input logic [1:0] sel,
                       input logic [2:0] p, input logic en, input logic ack, input logic done);
    irq_i = irq; cfg_we_i = we; cfg_sel_i = sel; cfg_prio_i = p; cfg_en_i = en;
    irq_ack_i = ack; irq_done_i = done;
  endtask

  initial begin
    // 1: basic offer and take, prio = {2,3,1}
    vc(0, 2, 1, 0); vc(1, 3, 1, 0); vc(2, 1, 1, 0);
    vp(3'b010, 0);
    vi(1, 1, 3, 0, 0);
    va(0, 1, 3, 1, 0);
    vi(0, 3, 0, 1, 0);
    vd(0, 3, 0, 0, 0);
    // 2: tie with base threshold, then raise source priority
    vc(3, 3, 0, 0); vc(0, 3, 1, 0);
    vp(3'b001, 0);
    vi(0, 3, 0, 0, 0); vi(0, 3, 0, 0, 0);
    vc(0, 4, 1, 0);
    vi(1, 0, 4, 0, 0);
    va(0, 0, 4, 1, 0);
    vd(0, 3, 0, 0, 0);
    vc(3, 0, 0, 0);
    // 3: nesting, low-prio source waits until fully unwound
    vc(0, 2, 1, 0);
    vp(3'b001, 0);
    vi(1, 0, 2, 0, 0);
    va(0, 0, 2, 1, 0);
    v(3'b100, 1, 1, 5, 1, 0, 0, 0, 3, 0, 1, 0);
    vp(3'b010, 1);
    vi(1, 1, 5, 1, 0);
    va(0, 1, 5, 2, 0);
    vi(0, 3, 0, 2, 0);
    vd(0, 3, 0, 1, 0);
    vd(0, 3, 0, 0, 0);
    vi(1, 2, 1, 0, 0);
    va(0, 2, 1, 1, 0);
    vd(0, 3, 0, 0, 0);
    // 4: fill all levels with prios 1..4, then a blocked prio-6 source
    for (int k = 1; k <= 4; k++) begin
      vc(0, 3'(k), 1, 3'(k - 1));
      vp(3'b001, 3'(k - 1));
      vi(1, 0, 3'(k), 3'(k - 1), 0);
      va(0, 0, 3'(k), 3'(k), 0);
    end
    vc(1, 6, 1, 4);
    vp(3'b010, 4);
    vi(0, 1, 6, 4, 0); vi(0, 1, 6, 4, 0);
    vd(0, 1, 6, 3, 0);
    vi(1, 1, 6, 3, 0);
    va(0, 1, 6, 4, 0);
    vd(0, 3, 0, 3, 0); vd(0, 3, 0, 2, 0); vd(0, 3, 0, 1, 0); vd(0, 3, 0, 0, 0);
    // 5: protocol errors
    va(0, 3, 0, 0, 1);
    vi(0, 3, 0, 0, 0);
    vd(0, 3, 0, 0, 1);
    vp(3'b100, 0);
    vi(1, 2, 1, 0, 0);
    v(3'b000, 0, 0, 0, 0, 1, 1, 0, 2, 1, 1, 1);
    vi(0, 3, 0, 1, 0);
    vd(0, 3, 0, 0, 0);
    // 6: new edge on the source being acked stays pending
    vp(3'b100, 0);
    vi(1, 2, 1, 0, 0);
    v(3'b100, 0, 0, 0, 0, 1, 0, 0, 2, 1, 1, 0);
    vi(0, 3, 0, 1, 0);
    vd(0, 3, 0, 0, 0);
    vi(1, 2, 1, 0, 0);
    va(0, 2, 1, 1, 0);

    rst_n = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset", 0, 3, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].irq, vecs[n].we, vecs[n].sel, vecs[n].p, vecs[n].en,
            vecs[n].ack, vecs[n].done);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d", n), vecs[n].req, vecs[n].id, vecs[n].prio,
          vecs[n].lvl, vecs[n].err);
    end

    // Asynchronous reset while a handler is active (level 1)
    #2;
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 3, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Config was cleared: an edge on src0 latches pending but is masked
    @(negedge clk); drive(3'b001, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; chk("post_rst_edge", 0, 3, 0, 0, 0);
    @(negedge clk); drive(3'b000, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; chk("post_rst_masked", 0, 3, 0, 0, 0);
    @(negedge clk); drive(3'b000, 1, 0, 5, 1, 0, 0);
    @(posedge clk); #1; chk("post_rst_cfg", 0, 3, 0, 0, 0);
    @(negedge clk); drive(3'b000, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; chk("post_rst_offer", 1, 0, 5, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
